// File: rtl/arb_mux_16_1_pkg.sv
// Shared constants and state encoding for the 16-to-1 round-robin collector.
package arb_mux_16_1_pkg;

  localparam int CHANNELS = 16;
  localparam int SEL_W    = 4;

  // The output register state is the same bit that drives out_valid.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/arb_mux_16_1_rr_pick.sv
// Combinational round-robin picker: rotate requests so ptr is bit 0,
// priority-encode the lowest set bit, then rotate the index back.
module rr_pick_16
  import arb_mux_16_1_pkg::*;
(
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [CHANNELS-1:0] grant,
  output logic [SEL_W-1:0]    idx,
  output logic                any_grant
);

  logic [2*CHANNELS-1:0] dbl;
  logic [CHANNELS-1:0]   rot;
  logic [SEL_W-1:0]      off;

  always_comb begin
    dbl       = {req, req} >> ptr;
    rot       = dbl[CHANNELS-1:0];
    off       = '0;
    any_grant = 1'b0;
    // Descending scan so the lowest set rotated bit wins.
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off       = SEL_W'(i);
        any_grant = 1'b1;
      end
    end
    idx   = ptr + off;
    grant = any_grant ? (CHANNELS'(1) << idx) : '0;
  end

endmodule

// File: rtl/arb_mux_16_1.sv
// Round-robin 16-to-1 gather with a single registered output stage; each
// output word is tagged with the index of the channel it came from.
module arb_mux_16_1
  import arb_mux_16_1_pkg::*;
#(
  parameter int bus_size = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          in_valid,
  input  logic [CHANNELS*bus_size-1:0] in_data,
  output logic [CHANNELS-1:0]          in_ready,
  output logic                         out_valid,
  output logic [bus_size-1:0]          out_data,
  output logic [SEL_W-1:0]             out_sel,
  input  logic                         out_ready
);

  // Handshake: a word moves on a rising clk edge when valid and ready are
  // both high in the cycle before it. in_ready is at most one-hot and only
  // rises when the output register is empty or is being drained this cycle.

  arb_state_e          state_q, state_d;
  logic [SEL_W-1:0]    ptr_q;
  logic [CHANNELS-1:0] grant;
  logic [SEL_W-1:0]    grant_idx;
  logic                any_grant;
  logic                can_load;
  logic                load;
  logic [bus_size-1:0] sel_data;

  rr_pick_16 u_pick (
    .req       (in_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .idx       (grant_idx),
    .any_grant (any_grant)
  );

  assign out_valid = (state_q == FULL);
  assign can_load  = (state_q == EMPTY) || out_ready;
  assign load      = can_load && any_grant;
  assign in_ready  = load ? grant : '0;
  assign sel_data  = in_data[grant_idx*bus_size +: bus_size];

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = FULL;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= EMPTY;
      out_data <= '0;
      out_sel  <= '0;
      ptr_q    <= '0;
    end else begin
      state_q <= state_d;
      if (load) begin
        out_data <= sel_data;
        out_sel  <= grant_idx;
        ptr_q    <= grant_idx + SEL_W'(1);
      end
    end
  end

endmodule
